// File: rtl/uart_echo_buffer_pkg.sv
// Shared definitions for the UART echo buffer:
//   - read-side FSM state encoding (2 bits)
//   - ASCII letter bounds and the case bit
//   - MODE codes and the byte case-swap helper
package uart_echo_buffer_pkg;

  // Read-side FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } echo_state_e;

  // ASCII letter ranges; upper and lower case differ only in bit 5
  localparam logic [7:0] ASCII_UC_LO    = 8'h41;
  localparam logic [7:0] ASCII_UC_HI    = 8'h5A;
  localparam logic [7:0] ASCII_LC_LO    = 8'h61;
  localparam logic [7:0] ASCII_LC_HI    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  // Echo modes
  localparam int unsigned MODE_ECHO = 0;
  localparam int unsigned MODE_SWAP = 1;

  // True for 'A'..'Z' and 'a'..'z'
  function automatic logic is_ascii_letter(input logic [7:0] b);
    return ((b >= ASCII_UC_LO) && (b <= ASCII_UC_HI)) ||
           ((b >= ASCII_LC_LO) && (b <= ASCII_LC_HI));
  endfunction

  // Flip the case of ASCII letters, pass everything else through
  function automatic logic [7:0] ascii_case_swap(input logic [7:0] b);
    return is_ascii_letter(b) ? (b ^ ASCII_CASE_BIT) : b;
  endfunction

endpackage

// File: rtl/uart_echo_buffer_sync_fifo.sv
// Single-clock FIFO used by the echo buffer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write din_i this cycle (ignored when full)
//   pop_i        : advance the read pointer this cycle (ignored when empty)
//   din_i        : write data
//   dout_c       : combinational read of the entry at the read pointer
//   count_o      : registered occupancy, 0..DEPTH
//   full_c       : count_o == DEPTH
//   empty_c      : count_o == 0
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
module uart_echo_buffer_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        din_i,
  output logic [DATA_W-1:0]        dout_c,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_c;
  logic              rd_en_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign wr_en_c = push_i && !full_c;
  assign rd_en_c = pop_i && !empty_c;
  assign dout_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({wr_en_c, rd_en_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care after reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo engine between uart_rx and uart_tx. Received bytes are queued in a
// FIFO and sent one at a time, optionally with ASCII case swapped.
// Ports:
//   ICE_CLK, ICE_RST_N : clock, asynchronous active-low reset
//   rx_dv, rx_byte     : one-cycle receive strobe and its byte
//   tx_done            : one-cycle end-of-frame strobe from uart_tx
//   tx_dv, tx_byte     : one-cycle start strobe and byte held until next load
//   led                : low LED_W bits of the last strobed rx byte
//   fifo_count         : FIFO occupancy
//   overflow           : sticky, set when a byte arrives while the FIFO is full
// MODE swap operates on bits [7:0]; DATA_W must be at least 8.
module uart_echo_buffer
  import uart_echo_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LED_W  = 5,
  parameter int unsigned MODE   = MODE_ECHO
) (
  input  logic                   ICE_CLK,
  input  logic                   ICE_RST_N,
  input  logic                   rx_dv,
  input  logic [DATA_W-1:0]      rx_byte,
  input  logic                   tx_done,
  output logic                   tx_dv,
  output logic [DATA_W-1:0]      tx_byte,
  output logic [LED_W-1:0]       led,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              pop_c;
  logic [DATA_W-1:0] fifo_dout_c;
  logic [DATA_W-1:0] xform_c;

  echo_state_e       state_q, state_d;
  logic              tx_dv_q, tx_dv_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic [LED_W-1:0]  led_q;
  logic              overflow_q;

  // Byte queue; a push into a full FIFO is discarded inside the FIFO
  uart_echo_buffer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (ICE_CLK),
    .rst_n   (ICE_RST_N),
    .push_i  (rx_dv),
    .pop_i   (pop_c),
    .din_i   (rx_byte),
    .dout_c  (fifo_dout_c),
    .count_o (fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Outbound transform; bits above 7 always pass through
  always_comb begin
    xform_c = fifo_dout_c;
    if (MODE == MODE_SWAP) begin
      xform_c[7:0] = ascii_case_swap(fifo_dout_c[7:0]);
    end
  end

  // Read-side FSM: next state and registered-output next values
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    pop_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Look at the incoming strobe as well so an empty FIFO reaches
        // LOAD one cycle after the write; no pop can happen in IDLE, so a
        // strobe here always ends up in the FIFO or the FIFO is non-empty.
        if (!fifo_empty_c || rx_dv) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_byte_d = xform_c;
        pop_c     = 1'b1;
        tx_dv_d   = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and transmit-side registers; tx_dv_q is high exactly in SEND
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      state_q   <= ST_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // LED mirror and sticky overflow; a drop is decided on the pre-pop count
  always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
    if (!ICE_RST_N) begin
      led_q      <= '0;
      overflow_q <= 1'b0;
    end else if (rx_dv) begin
      led_q <= rx_byte[LED_W-1:0];
      if (fifo_full_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign tx_dv    = tx_dv_q;
  assign tx_byte  = tx_byte_q;
  assign led      = led_q;
  assign overflow = overflow_q;

endmodule
